acc_job_arbiter: RTL and testbench

//  Time-shares one add/sub accumulator datapath between two requesters. Each requester

---
 rtl/acc_pkg.sv | 15 +
 rtl/acc_addsub_dp.sv | 62 ++++++
 rtl/acc_job_arbiter.sv | 176 +++++++++++++++++
 tb/tb_acc_job_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared definitions for the two-requester accumulator job arbiter.
package acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Pipeline depth behind the operand port: operand register, then sum register.
  localparam int unsigned DRAIN_CYC = 2;
  localparam int unsigned DRAIN_W   = $clog2(DRAIN_CYC);

endpackage

// File: rtl/acc_addsub_dp.sv
// Add/sub accumulator datapath: operand register stage feeding one adder into the sum register.
module acc_addsub_dp #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             sub,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sum,
  output logic             ovf,
  output logic             carry
);

  localparam int unsigned SUM_W = WIDTH + 1;

  logic [WIDTH-1:0] d_q;
  logic             sub_q;
  logic             pend_q;
  logic [WIDTH-1:0] b_c;
  logic [WIDTH-1:0] r_c;
  logic             cout_c;
  logic             v_c;

  // Subtract is acc + ~d + 1, so cin follows the sub flag.
  always_comb begin
    b_c           = sub_q ? ~d_q : d_q;
    {cout_c, r_c} = SUM_W'({1'b0, sum}) + SUM_W'({1'b0, b_c}) + SUM_W'(sub_q);
    v_c           = (sum[WIDTH-1] == b_c[WIDTH-1]) && (r_c[WIDTH-1] != sum[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q    <= '0;
      sub_q  <= 1'b0;
      pend_q <= 1'b0;
      sum    <= '0;
      ovf    <= 1'b0;
      carry  <= 1'b0;
    end else if (clr) begin
      d_q    <= '0;
      sub_q  <= 1'b0;
      pend_q <= 1'b0;
      sum    <= '0;
      ovf    <= 1'b0;
      carry  <= 1'b0;
    end else begin
      pend_q <= en;
      if (en) begin
        d_q   <= d;
        sub_q <= sub;
      end
      if (pend_q) begin
        sum   <= r_c;
        ovf   <= ovf | v_c;
        carry <= cout_c;
      end
    end
  end

endmodule

// File: rtl/acc_job_arbiter.sv
// Round-robin job arbiter time-sharing one add/sub accumulator between two requesters.
module acc_job_arbiter
  import acc_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_LEN = 16,
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [2*LEN_W-1:0] len,
  output logic [1:0]         gnt,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [WIDTH-1:0]   op_data,
  input  logic               op_sub,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_data,
  output logic               res_ovf,
  output logic               res_carry,
  output logic               res_id
);

  state_e             state_q, state_d;
  logic               id_q, id_d;
  logic               ptr_q, ptr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [1:0]         gnt_d;
  logic               op_ready_d;
  logic               res_valid_d;
  logic [WIDTH-1:0]   res_data_d;
  logic               res_ovf_d;
  logic               res_carry_d;
  logic               res_id_d;

  logic               accept_c;
  logic               clr_c;
  logic               win_c;
  logic [LEN_W-1:0]   len_sel_c;
  logic [LEN_W-1:0]   len_sat_c;
  logic [WIDTH-1:0]   sum;
  logic               ovf;
  logic               carry;

  assign accept_c = op_valid & op_ready;

  // Winner selection and length saturation for a job starting this cycle.
  always_comb begin
    win_c     = (req == 2'b11) ? ptr_q : req[1];
    len_sel_c = win_c ? len[2*LEN_W-1:LEN_W] : len[LEN_W-1:0];
    len_sat_c = (len_sel_c > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_sel_c;
  end

  acc_addsub_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_c),
    .en   (accept_c),
    .sub  (op_sub),
    .d    (op_data),
    .sum  (sum),
    .ovf  (ovf),
    .carry(carry)
  );

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    gnt_d       = gnt;
    op_ready_d  = 1'b0;
    res_valid_d = res_valid;
    res_data_d  = res_data;
    res_ovf_d   = res_ovf;
    res_carry_d = res_carry;
    res_id_d    = res_id;
    clr_c       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          id_d  = win_c;
          len_d = len_sat_c;
          cnt_d = '0;
          clr_c = 1'b1;
          gnt_d = win_c ? 2'b10 : 2'b01;
          // An empty job skips straight to a zero result.
          if (len_sat_c == '0) begin
            state_d     = DONE;
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_ovf_d   = 1'b0;
            res_carry_d = 1'b0;
            res_id_d    = win_c;
          end else begin
            state_d    = RUN;
            op_ready_d = 1'b1;
          end
        end
      end
      RUN: begin
        op_ready_d = 1'b1;
        if (accept_c) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d    = DRAIN;
            op_ready_d = 1'b0;
            drain_d    = '0;
          end
        end
      end
      DRAIN: begin
        drain_d = drain_q + DRAIN_W'(1);
        if (drain_q == DRAIN_W'(DRAIN_CYC - 1)) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_data_d  = sum;
          res_ovf_d   = ovf;
          res_carry_d = carry;
          res_id_d    = id_q;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          gnt_d       = 2'b00;
          ptr_d       = ~id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      id_q      <= 1'b0;
      ptr_q     <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      drain_q   <= '0;
      gnt       <= 2'b00;
      op_ready  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ovf   <= 1'b0;
      res_carry <= 1'b0;
      res_id    <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      gnt       <= gnt_d;
      op_ready  <= op_ready_d;
      res_valid <= res_valid_d;
      res_data  <= res_data_d;
      res_ovf   <= res_ovf_d;
      res_carry <= res_carry_d;
      res_id    <= res_id_d;
    end
  end

endmodule

// File: tb/tb_acc_job_arbiter.sv
// Directed self-checking bench for acc_job_arbiter with hand-computed results.
module tb_acc_job_arbiter;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned LEN_W   = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         req;
  logic [2*LEN_W-1:0] len;
  logic [1:0]         gnt;
  logic               op_valid;
  logic               op_ready;
  logic [WIDTH-1:0]   op_data;
  logic               op_sub;
  logic               res_valid;
  logic               res_ready;
  logic [WIDTH-1:0]   res_data;
  logic               res_ovf;
  logic               res_carry;
  logic               res_id;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] tab_d [20];
  logic             tab_s [20];

  logic [WIDTH-1:0] r_data;
  logic             r_ovf, r_carry, r_id;
  logic [1:0]       r_gnt, r_gnt_after;
  logic             r_valid_after;
  int               r_acc, r_lat;
  bit               r_timeout, r_stable, r_onehot, r_saw_ready;

  always #5 clk = ~clk;

  acc_job_arbiter #(
    .WIDTH  (WIDTH),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .len      (len),
    .gnt      (gnt),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_data  (op_data),
    .op_sub   (op_sub),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_ovf  (res_ovf),
    .res_carry(res_carry),
    .res_id   (res_id)
  );

  // Drives one job: waits for a grant, offers n operands, collects the result, holds res_ready low for hold cycles.
  task automatic run_job(input logic [1:0] req_v, input logic [LEN_W-1:0] l0,
                         input logic [LEN_W-1:0] l1, input int n, input int hold);
    int  wait_c;
    int  c;
    int  idx;
    int  acc_edge;
    bit  acc;
    r_timeout = 0; r_stable = 1; r_onehot = 1; r_saw_ready = 0;
    r_acc = 0; r_lat = -1; acc_edge = -1; idx = 0; c = 0;
    r_gnt_after = 2'b11; r_valid_after = 1'b1; r_gnt = 2'b00;
    req = req_v;
    len = {l1, l0};
    wait_c = 0;
    while (gnt == 2'b00 && wait_c < 50) begin
      @(posedge clk); #1; wait_c++;
    end
    if (gnt == 2'b00) begin
      r_timeout = 1;
      return;
    end
    r_gnt = gnt;
    while (!res_valid && c < 100) begin
      if (!$onehot(gnt)) r_onehot = 0;
      if (op_ready) r_saw_ready = 1;
      op_valid = (idx < n);
      op_data  = (idx < n) ? tab_d[idx] : '0;
      op_sub   = (idx < n) ? tab_s[idx] : 1'b0;
      acc      = op_valid && op_ready;
      @(posedge clk);
      c++;
      if (acc) begin
        idx++; r_acc++; acc_edge = c;
      end
      #1;
    end
    op_valid = 1'b0;
    op_sub   = 1'b0;
    if (!res_valid) begin
      r_timeout = 1;
      return;
    end
    if (acc_edge >= 0) r_lat = c - acc_edge;
    r_data = res_data; r_ovf = res_ovf; r_carry = res_carry; r_id = res_id;
    if (!$onehot(gnt)) r_onehot = 0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (!res_valid || res_data !== r_data || res_ovf !== r_ovf ||
          res_carry !== r_carry || res_id !== r_id || gnt !== r_gnt) r_stable = 0;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    r_gnt_after   = gnt;
    r_valid_after = res_valid;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; len = '0; op_valid = 1'b0; op_data = '0; op_sub = 1'b0; res_ready = 1'b0;
    #1;
    checks++;
    if ({gnt, op_ready, res_valid, res_data, res_ovf, res_carry, res_id} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b rdy=%b vld=%b data=%h ovf=%b c=%b id=%b, want all 0",
               gnt, op_ready, res_valid, res_data, res_ovf, res_carry, res_id);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (gnt !== 2'b00 || op_ready !== 1'b0) begin
      errors++; $display("FAIL reset_idle: gnt=%b op_ready=%b, want 00/0 with no request", gnt, op_ready);
    end
  endtask

  task automatic test_basic();
    tab_d[0] = 8'd10; tab_s[0] = 0; tab_d[1] = 8'd20; tab_s[1] = 0; tab_d[2] = 8'd30; tab_s[2] = 0;
    run_job(2'b01, 5'd3, 5'd0, 3, 0);
    req = 2'b00;
    checks++;
    if (r_timeout) begin errors++; $display("FAIL basic_timeout: job did not complete"); end
    checks++;
    if (r_gnt !== 2'b01) begin errors++; $display("FAIL basic_gnt: got %b want 01", r_gnt); end
    checks++;
    if ({r_data, r_ovf, r_carry, r_id} !== {8'd60, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL basic_result: got data=%0d ovf=%b c=%b id=%b want 60/0/0/0", r_data, r_ovf, r_carry, r_id);
    end
    // Last accept in cycle T closes at edge E; res_valid rises at edge E+2, i.e. visible in cycle T+3.
    checks++;
    if (r_lat !== 2) begin errors++; $display("FAIL basic_latency: got %0d edges want 2 (T+3)", r_lat); end
    checks++;
    if (r_acc !== 3) begin errors++; $display("FAIL basic_accepts: got %0d want 3", r_acc); end
    checks++;
    if (r_gnt_after !== 2'b00 || r_valid_after !== 1'b0) begin
      errors++; $display("FAIL basic_release: gnt=%b res_valid=%b after handshake, want 00/0", r_gnt_after, r_valid_after);
    end
  endtask

  task automatic test_overflow();
    tab_d[0] = 8'd100; tab_s[0] = 0; tab_d[1] = 8'd50; tab_s[1] = 0; tab_d[2] = 8'd100; tab_s[2] = 1;
    run_job(2'b10, 5'd0, 5'd3, 3, 0);
    req = 2'b00;
    checks++;
    if (r_timeout) begin errors++; $display("FAIL ovf_timeout: job did not complete"); end
    checks++;
    if ({r_data, r_ovf, r_carry, r_id} !== {8'h32, 1'b1, 1'b1, 1'b1}) begin
      errors++; $display("FAIL ovf_result: got data=%h ovf=%b c=%b id=%b want 32/1/1/1", r_data, r_ovf, r_carry, r_id);
    end
    checks++;
    if (r_gnt !== 2'b10) begin errors++; $display("FAIL ovf_gnt: got %b want 10", r_gnt); end
  endtask

  task automatic test_sub();
    tab_d[0] = 8'd5; tab_s[0] = 0; tab_d[1] = 8'd7; tab_s[1] = 1;
    run_job(2'b01, 5'd2, 5'd0, 2, 0);
    req = 2'b00;
    checks++;
    if (r_timeout || {r_data, r_ovf, r_carry} !== {8'hFE, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sub_borrow: got data=%h ovf=%b c=%b to=%0d want FE/0/0", r_data, r_ovf, r_carry, r_timeout);
    end
    tab_d[0] = 8'd7; tab_s[0] = 0; tab_d[1] = 8'd5; tab_s[1] = 1;
    run_job(2'b10, 5'd0, 5'd2, 2, 0);
    req = 2'b00;
    checks++;
    if (r_timeout || {r_data, r_ovf, r_carry, r_id} !== {8'h02, 1'b0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL sub_noborrow: got data=%h ovf=%b c=%b id=%b want 02/0/1/1", r_data, r_ovf, r_carry, r_id);
    end
  endtask

  task automatic test_round_robin();
    logic       exp_id [3];
    logic [7:0] exp_d  [3];
    exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0;
    exp_d[0]  = 8'd7; exp_d[1]  = 8'd9; exp_d[2]  = 8'd7;
    for (int j = 0; j < 3; j++) begin
      if (exp_id[j]) begin
        tab_d[0] = 8'd9; tab_s[0] = 0;
      end else begin
        tab_d[0] = 8'd3; tab_s[0] = 0; tab_d[1] = 8'd4; tab_s[1] = 0;
      end
      run_job(2'b11, 5'd2, 5'd1, exp_id[j] ? 1 : 2, 0);
      checks++;
      if (r_timeout || r_id !== exp_id[j] || r_gnt !== (exp_id[j] ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_grant%0d: got id=%b gnt=%b to=%0d want id=%b", j, r_id, r_gnt, r_timeout, exp_id[j]);
      end
      checks++;
      if (r_data !== exp_d[j] || !r_onehot || r_gnt_after !== 2'b00) begin
        errors++; $display("FAIL rr_job%0d: got data=%0d onehot=%0d gnt_after=%b want %0d/1/00", j, r_data, r_onehot, r_gnt_after, exp_d[j]);
      end
    end
    req = 2'b00;
  endtask

  task automatic test_len_edges();
    run_job(2'b01, 5'd0, 5'd0, 0, 0);
    req = 2'b00;
    checks++;
    if (r_timeout || r_saw_ready || r_acc !== 0) begin
      errors++; $display("FAIL len0_ready: to=%0d saw_ready=%0d accepts=%0d want 0/0/0", r_timeout, r_saw_ready, r_acc);
    end
    checks++;
    if ({r_data, r_ovf, r_carry, r_id} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL len0_result: got data=%h ovf=%b c=%b id=%b want 00/0/0/0", r_data, r_ovf, r_carry, r_id);
    end
    for (int k = 0; k < 20; k++) begin
      tab_d[k] = 8'd1; tab_s[k] = 0;
    end
    run_job(2'b01, 5'd31, 5'd0, 20, 0);
    req = 2'b00;
    checks++;
    if (r_timeout || r_acc !== 16) begin
      errors++; $display("FAIL len31_accepts: got %0d to=%0d want 16", r_acc, r_timeout);
    end
    checks++;
    if (r_data !== 8'd16 || r_ovf !== 1'b0) begin
      errors++; $display("FAIL len31_result: got data=%0d ovf=%b want 16/0", r_data, r_ovf);
    end
  endtask

  task automatic test_hold();
    tab_d[0] = 8'd42; tab_s[0] = 0;
    run_job(2'b10, 5'd0, 5'd1, 1, 5);
    req = 2'b00;
    checks++;
    if (r_timeout || !r_stable || r_data !== 8'd42 || r_id !== 1'b1) begin
      errors++; $display("FAIL hold_stable: stable=%0d data=%0d id=%b to=%0d want 1/42/1/0", r_stable, r_data, r_id, r_timeout);
    end
  endtask

  task automatic test_reset_mid_run();
    int w;
    req = 2'b01;
    len = {5'd0, 5'd5};
    w = 0;
    while (!op_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    checks++;
    if (!op_ready) begin errors++; $display("FAIL midrst_start: op_ready=%b want 1", op_ready); end
    op_valid = 1'b1; op_data = 8'd50; op_sub = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({gnt, op_ready, res_valid, res_data, res_ovf, res_carry, res_id} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got gnt=%b rdy=%b vld=%b data=%h ovf=%b c=%b id=%b want all 0",
               gnt, op_ready, res_valid, res_data, res_ovf, res_carry, res_id);
    end
    op_valid = 1'b0; req = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    tab_d[0] = 8'd1; tab_s[0] = 0; tab_d[1] = 8'd2; tab_s[1] = 0;
    run_job(2'b01, 5'd2, 5'd0, 2, 0);
    req = 2'b00;
    checks++;
    if (r_timeout || {r_data, r_ovf, r_carry, r_id} !== {8'd3, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL midrst_clean: got data=%0d ovf=%b c=%b id=%b to=%0d want 3/0/0/0", r_data, r_ovf, r_carry, r_id, r_timeout);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_sub();
    test_round_robin();
    test_len_edges();
    test_hold();
    test_reset_mid_run();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
